uart_prog_loader: RTL and testbench

- Sits directly downstream of the UART receiver.
- Consumes received bytes (data + ready) and parses a framed program image: a 4-byte word count followed by the instruction words.
- Writes each assembled 32-bit word into the RV32I instruction memory.
- Holds the CPU core in reset while a load is in progress or after a failed load; releases it on successful completion.

---
 rtl/uart_prog_loader.sv | 195 +++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program-image loader: parses {count[31:0] LE, words...} from the UART byte stream into IMEM.
// Optional trailing XOR checksum byte when UART_LOADER_CSUM_EN is defined.
module uart_prog_loader #(
   parameter int                         ADDR_WIDTH     = 10,
   parameter int                         TIMEOUT_WIDTH  = 24,
   parameter logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_CYCLES = 24'd5000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [32:0]              MAX_WORDS = 33'd1 << ADDR_WIDTH;
   localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                  r_state;
   logic                    r_rx_ready_q;
   logic [1:0]              r_byte_cnt;
   logic [31:0]             r_buf;
   logic [ADDR_WIDTH-1:0]   r_word_idx;
   logic [ADDR_WIDTH-1:0]   r_last_idx;
   logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
   logic                    r_imem_we;
   logic [ADDR_WIDTH-1:0]   r_imem_addr;
   logic [31:0]             r_imem_wdata;
   logic                    r_cpu_rst;
   logic                    r_busy;
   logic                    r_load_done;
   logic                    r_load_err;
`ifdef UART_LOADER_CSUM_EN
   logic [7:0]              r_xor;
`endif

   logic        w_stb;
   logic [31:0] w_word;
   logic        w_timed;
   logic        w_to_hit;
   logic        w_too_big;

   assign w_stb     = rx_ready & ~r_rx_ready_q;
   assign w_word    = {rx_data, r_buf[31:8]};
   assign w_timed   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
   // Expiry fires on the edge where the counter would reach TIMEOUT_CYCLES; a strobe in that cycle wins.
   assign w_to_hit  = w_timed && !w_stb && (r_to_cnt >= TO_LAST);
   assign w_too_big = {1'b0, w_word} > MAX_WORDS;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rx_ready_q <= 1'b1;
         r_byte_cnt   <= '0;
         r_buf        <= '0;
         r_word_idx   <= '0;
         r_last_idx   <= '0;
         r_to_cnt     <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_cpu_rst    <= 1'b0;
         r_busy       <= 1'b0;
         r_load_done  <= 1'b0;
         r_load_err   <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
         r_xor        <= '0;
`endif
      end else begin
         r_rx_ready_q <= rx_ready;
         r_imem_we    <= 1'b0;
         r_load_done  <= 1'b0;

         if (!w_timed || w_stb)
            r_to_cnt <= '0;
         else if (r_to_cnt != TIMEOUT_CYCLES)
            r_to_cnt <= r_to_cnt + TIMEOUT_WIDTH'(1);

         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (w_stb) begin
                  r_state    <= S_LEN;
                  r_byte_cnt <= 2'd1;
                  r_buf      <= w_word;
                  r_load_err <= 1'b0;
                  r_cpu_rst  <= 1'b1;
                  r_busy     <= 1'b1;
`ifdef UART_LOADER_CSUM_EN
                  r_xor      <= '0;
`endif
               end else if (r_state == S_DONE) begin
                  r_state   <= S_IDLE;
                  r_cpu_rst <= 1'b0;
               end
            end

            S_LEN: begin
               if (w_stb) begin
                  r_buf      <= w_word;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     if (w_word == 32'd0) begin
                        r_state     <= S_DONE;
                        r_load_done <= 1'b1;
                        r_busy      <= 1'b0;
                     end else if (w_too_big) begin
                        r_state    <= S_ERR;
                        r_load_err <= 1'b1;
                        r_busy     <= 1'b0;
                     end else begin
                        r_state    <= S_DATA;
                        r_word_idx <= '0;
                        r_last_idx <= ADDR_WIDTH'(w_word - 32'd1);
                     end
                  end
               end else if (w_to_hit) begin
                  r_state    <= S_ERR;
                  r_load_err <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end

            S_DATA: begin
               if (w_stb) begin
                  r_buf      <= w_word;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef UART_LOADER_CSUM_EN
                  r_xor      <= r_xor ^ rx_data;
`endif
                  if (r_byte_cnt == 2'd3) begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_word_idx;
                     r_imem_wdata <= w_word;
                     r_word_idx   <= r_word_idx + ADDR_WIDTH'(1);
                     if (r_word_idx == r_last_idx) begin
`ifdef UART_LOADER_CSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state     <= S_DONE;
                        r_load_done <= 1'b1;
                        r_busy      <= 1'b0;
`endif
                     end
                  end
               end else if (w_to_hit) begin
                  r_state    <= S_ERR;
                  r_load_err <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end

            S_CSUM: begin
`ifdef UART_LOADER_CSUM_EN
               if (w_stb) begin
                  r_busy <= 1'b0;
                  if (rx_data == r_xor) begin
                     r_state     <= S_DONE;
                     r_load_done <= 1'b1;
                  end else begin
                     r_state    <= S_ERR;
                     r_load_err <= 1'b1;
                  end
               end else if (w_to_hit) begin
                  r_state    <= S_ERR;
                  r_load_err <= 1'b1;
                  r_busy     <= 1'b0;
               end
`else
               r_state <= S_IDLE;
`endif
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign cpu_rst    = r_cpu_rst;
   assign busy       = r_busy;
   assign load_done  = r_load_done;
   assign load_err   = r_load_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a byte-stream model predicts writes/done/err events and their latency.
module tb_uart_prog_loader;
   localparam int AW = 10;
   localparam int TO = 1000;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int          kind;   // 0 write, 1 done, 2 err
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;    // clock edges after the last byte strobe
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_ready = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst, busy, load_done, load_err;

   uart_prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(24), .TIMEOUT_CYCLES(24'd1000)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .busy(busy), .load_done(load_done), .load_err(load_err));

   always #5 clk = ~clk;

   int  cyc = 0;
   int  last_stb_edge = 0;
   int  vectors = 0;
   int  miscompares = 0;
   ev_t q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic pop_expect(input int kind);
      ev_t e;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
         e = q.pop_front();
         chk("event_kind", 64'(kind), 64'(e.kind));
         if (kind == 0 && e.kind == 0) begin
            chk("imem_addr", 64'(imem_addr), 64'(e.addr));
            chk("imem_wdata", 64'(imem_wdata), 64'(e.data));
         end
         chk("event_latency", 64'(cyc - last_stb_edge), 64'(e.lat));
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write, a done pulse or a new error.
   logic prev_err = 1'b0;
   bit   done_seen = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_err  = 1'b0;
         done_seen = 1'b0;
      end else begin
         if (done_seen) begin
            chk("cpu_rst_release", 64'(cpu_rst), 64'd0);
            done_seen = 1'b0;
         end
         if (imem_we) pop_expect(0);
         if (load_done) begin
            pop_expect(1);
            chk("cpu_rst_in_done", 64'(cpu_rst), 64'd1);
            done_seen = 1'b1;
         end
         if (load_err && !prev_err) begin
            pop_expect(2);
            chk("cpu_rst_in_err", 64'(cpu_rst), 64'd1);
         end
         prev_err = load_err;
      end
   end

   function automatic ev_t mk(input int kind, input logic [31:0] a, input logic [31:0] d, input int lat);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d; e.lat = lat;
      return e;
   endfunction

   // Reference: parse the whole byte stream at once; idle=1 means the bus then stays quiet past the timeout.
   task automatic model(input bq_t b, input bit idle);
      int unsigned len;
      int          n;
      logic [7:0]  x;
      n = b.size();
      if (n < 4) begin
         if (idle && n > 0) q.push_back(mk(2, 0, 0, TO));
         return;
      end
      len = {b[3], b[2], b[1], b[0]};
      if (len == 0) begin q.push_back(mk(1, 0, 0, 0)); return; end
      if (len > (1 << AW)) begin q.push_back(mk(2, 0, 0, 0)); return; end
      x = 8'h00;
      for (int w = 0; w < int'(len); w++) begin
         if (4 + 4*w + 3 >= n) begin
            if (idle) q.push_back(mk(2, 0, 0, TO));
            return;
         end
         q.push_back(mk(0, w, {b[4*w+7], b[4*w+6], b[4*w+5], b[4*w+4]}, 0));
         x = x ^ b[4*w+4] ^ b[4*w+5] ^ b[4*w+6] ^ b[4*w+7];
      end
`ifdef UART_LOADER_CSUM_EN
      if (n > 4 + 4*int'(len)) q.push_back(mk(b[4 + 4*len] == x ? 1 : 2, 0, 0, 0));
      else if (idle) q.push_back(mk(2, 0, 0, TO));
`else
      q.push_back(mk(1, 0, 0, 0));
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      rx_data = b;
      rx_ready = 1'b1;
      last_stb_edge = cyc + 1;
      repeat (hold) @(negedge clk);
      rx_ready = 1'b0;
      rx_data = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic send_stream(input bq_t b, input bit idle);
      model(b, idle);
      foreach (b[i]) send_byte(b[i], $urandom_range(1, 4));
      if (idle) repeat (TO + 10) @(negedge clk);
      else repeat (8) @(negedge clk);
   endtask

   function automatic bq_t mk_img(input logic [31:0] len, input int nw, input bit add_csum, input bit bad_csum);
      bq_t b;
      logic [31:0] w;
      logic [7:0]  x;
      x = 8'h00;
      for (int i = 0; i < 4; i++) b.push_back(len[8*i +: 8]);
      for (int k = 0; k < nw; k++) begin
         w = $urandom;
         for (int i = 0; i < 4; i++) begin
            b.push_back(w[8*i +: 8]);
            x = x ^ w[8*i +: 8];
         end
      end
      if (add_csum) b.push_back(bad_csum ? ~x : x);
      return b;
   endfunction

   initial begin
      #(80000 * 10);
      $display("FAIL watchdog: got no finish expected finish within 80000 cycles");
      $fatal(1);
   end

   initial begin
      bq_t b;
      int  mode, nw, cut;
      bit  cs;
`ifdef UART_LOADER_CSUM_EN
      cs = 1'b1;
`else
      cs = 1'b0;
`endif
      // Reset with rx_ready already high: no byte may be seen at release.
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_imem_we", 64'(imem_we), 64'd0);
      chk("rst_cpu_rst", 64'(cpu_rst), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done_err", 64'({load_done, load_err}), 64'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rx_high_at_release_busy", 64'(busy), 64'd0);
      chk("rx_high_at_release_cpu_rst", 64'(cpu_rst), 64'd0);
      rx_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Two-word image, byte by byte so cpu_rst can be checked after the first byte.
      b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      if (cs) b.push_back(8'h13 ^ 8'h93 ^ 8'h10);
      model(b, 1'b0);
      send_byte(b[0], 2);
      chk("cpu_rst_after_first_byte", 64'(cpu_rst), 64'd1);
      chk("busy_after_first_byte", 64'(busy), 64'd1);
      for (int i = 1; i < b.size(); i++) send_byte(b[i], $urandom_range(1, 4));
      repeat (8) @(negedge clk);
      chk("img2_cpu_rst", 64'(cpu_rst), 64'd0);
      chk("img2_load_err", 64'(load_err), 64'd0);

      // Zero length.
      send_stream('{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
      chk("len0_cpu_rst", 64'(cpu_rst), 64'd0);

      // One word over the bound, then a valid one-word load.
      send_stream('{8'h01, 8'h04, 8'h00, 8'h00}, 1'b0);
      chk("toobig_err", 64'(load_err), 64'd1);
      chk("toobig_cpu_rst", 64'(cpu_rst), 64'd1);
      send_stream(mk_img(32'd1, 1, cs, 1'b0), 1'b0);
      chk("after_err_ok_err", 64'(load_err), 64'd0);
      chk("after_err_ok_cpu_rst", 64'(cpu_rst), 64'd0);

      // Truncated word with a 50-cycle rx_ready high period, then timeout.
      b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55};
      model(b, 1'b1);
      for (int i = 0; i < 5; i++) send_byte(b[i], 1);
      send_byte(b[5], 50);
      repeat (TO + 10) @(negedge clk);
      chk("timeout_err", 64'(load_err), 64'd1);
      chk("timeout_cpu_rst", 64'(cpu_rst), 64'd1);

      // Reset after 6 bytes of a two-word load, then a fresh load from address 0.
      b = mk_img(32'd2, 2, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(b[i], $urandom_range(1, 3));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_cpu_rst", 64'(cpu_rst), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      send_stream(mk_img(32'd2, 2, cs, 1'b0), 1'b0);

`ifdef UART_LOADER_CSUM_EN
      send_stream('{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, 1'b0);
      chk("csum_ok_err", 64'(load_err), 64'd0);
      send_stream('{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12}, 1'b0);
      chk("csum_bad_err", 64'(load_err), 64'd1);
      chk("csum_bad_cpu_rst", 64'(cpu_rst), 64'd1);
`endif

      // Randomized images.
      for (int it = 0; it < 24; it++) begin
         mode = $urandom_range(0, 7);
         nw = $urandom_range(1, 6);
         case (mode)
            0: send_stream(mk_img(32'd0, 0, 1'b0, 1'b0), 1'b0);
            1: send_stream(mk_img(32'd1025 + ($urandom % 1000), 0, 1'b0, 1'b0), 1'b0);
            2: begin
               b = mk_img(nw, nw, cs, 1'b0);
               cut = $urandom_range(1, b.size() - 1);
               while (b.size() > cut) void'(b.pop_back());
               send_stream(b, 1'b1);
            end
            3: send_stream(mk_img(nw, nw, cs, cs && ($urandom_range(0, 1) == 1)), 1'b0);
            default: send_stream(mk_img(nw, nw, cs, 1'b0), 1'b0);
         endcase
      end

      repeat (10) @(negedge clk);
      if (q.size() != 0) chk("events_left_in_scoreboard", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
